// File: rtl/tron_pkg.sv
// Shared Tron definitions: instruction width, the NOP word and the
// fetch state encoding used by fetch, decode and the controller.
package tron_pkg;

  localparam int INSTR_W = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Tron instruction fetch: owns the PC, reads words via mem_rd/mem_ready
// and loads the IR; redirects retarget the PC and squash the old path.
// Ports: clk, reset (async high), fetch_req, redirect, redirect_pc,
//   mem_addr, mem_rd, mem_rdata, mem_ready, ir, ir_valid, pc, busy.
module instr_fetch
  import tron_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_req,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_ready,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               ir_valid_q, ir_valid_d;
  logic               mem_rd_q, mem_rd_d;
  logic               busy_q, busy_d;
  // set when the PC moved under an outstanding read; the next returned
  // word belongs to the old path and must be dropped
  logic               kill_q, kill_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = 1'b0;
    mem_rd_d   = mem_rd_q;
    busy_d     = busy_q;
    kill_d     = kill_q;
    unique case (state_q)
      IDLE: begin
        if (redirect) begin
          pc_d = redirect_pc;
        end
        if (fetch_req) begin
          state_d  = FETCH;
          mem_rd_d = 1'b1;
          busy_d   = 1'b1;
        end
      end
      FETCH: begin
        if (mem_ready) begin
          if (kill_q || redirect) begin
            // stale word: stay in FETCH and refetch from the new PC
            if (redirect) begin
              pc_d = redirect_pc;
            end
            kill_d = 1'b0;
          end else begin
            ir_d       = mem_rdata;
            pc_d       = pc_q + ADDR_W'(1);
            ir_valid_d = 1'b1;
            mem_rd_d   = 1'b0;
            busy_d     = 1'b0;
            state_d    = IDLE;
          end
        end else if (redirect) begin
          pc_d   = redirect_pc;
          kill_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= NOP_INSTR;
      ir_valid_q <= 1'b0;
      mem_rd_q   <= 1'b0;
      busy_q     <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      mem_rd_q   <= mem_rd_d;
      busy_q     <= busy_d;
      kill_q     <= kill_d;
    end
  end

  assign mem_addr = pc_q;
  assign pc       = pc_q;
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign mem_rd   = mem_rd_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a
// randomized fetch stream checked against a transaction-level model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [15:0] ir;
  logic        ir_valid;
  logic [15:0] pc;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // model state: where the next fetch will read from, and the IR word
  logic [15:0] model_pc;
  logic [15:0] model_ir;

  instr_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .ir(ir), .ir_valid(ir_valid), .pc(pc),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] w;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++;
    if (pc !== 16'h0000 || ir !== 16'h0000 || ir_valid !== 1'b0 ||
        mem_rd !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_init got pc=%h ir=%h v=%b rd=%b busy=%b exp 0",
               pc, ir, ir_valid, mem_rd, busy);
    end
    w = 16'($urandom) | 16'h8001;
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = w;
    step();
    mem_ready = 1'b0;
    checks++;
    if (ir !== w) begin
      errors++;
      $display("FAIL reset_preload got ir=%h exp %h", ir, w);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (pc !== 16'h0000 || ir !== 16'h0000 || ir_valid !== 1'b0 ||
        mem_rd !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_async got pc=%h ir=%h v=%b rd=%b busy=%b exp 0",
               pc, ir, ir_valid, mem_rd, busy);
    end
    #1;
    reset = 1'b0;
    model_pc = 16'h0000;
    model_ir = 16'h0000;
  endtask

  task automatic test_zero_wait();
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    checks++;
    if (mem_rd !== 1'b1 || busy !== 1'b1 || mem_addr !== model_pc ||
        ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL zw_accept got rd=%b busy=%b addr=%h v=%b exp 1 1 %h 0",
               mem_rd, busy, mem_addr, ir_valid, model_pc);
    end
    mem_ready = 1'b1;
    mem_rdata = 16'h1234;
    step();
    mem_ready = 1'b0;
    checks++;
    if (ir !== 16'h1234 || ir_valid !== 1'b1 || pc !== 16'h0001 ||
        mem_rd !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zw_load got ir=%h v=%b pc=%h rd=%b busy=%b exp 1234 1 0001 0 0",
               ir, ir_valid, pc, mem_rd, busy);
    end
    step();
    checks++;
    if (ir_valid !== 1'b0 || ir !== 16'h1234) begin
      errors++;
      $display("FAIL zw_pulse got v=%b ir=%h exp 0 1234", ir_valid, ir);
    end
    model_pc = 16'h0001;
    model_ir = 16'h1234;
  endtask

  task automatic test_wait_states();
    int bad = 0;
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (mem_rd !== 1'b1 || mem_addr !== model_pc || ir_valid !== 1'b0)
        bad++;
      if (i == 3) begin
        mem_ready = 1'b1;
        mem_rdata = 16'h2ABC;
      end
      step();
    end
    mem_ready = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ws_hold got %0d bad wait cycles exp 0", bad);
    end
    checks++;
    if (ir !== 16'h2ABC || ir_valid !== 1'b1 || pc !== model_pc + 16'd1) begin
      errors++;
      $display("FAIL ws_load got ir=%h v=%b pc=%h exp 2abc 1 %h",
               ir, ir_valid, pc, model_pc + 16'd1);
    end
    model_pc = model_pc + 16'd1;
    model_ir = 16'h2ABC;
    step();
  endtask

  task automatic test_redirect_kill();
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    step();
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    step();
    redirect = 1'b0;
    checks++;
    if (pc !== 16'h0040 || mem_addr !== 16'h0040 || mem_rd !== 1'b1 ||
        ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL rk_redir got pc=%h addr=%h rd=%b v=%b exp 0040 0040 1 0",
               pc, mem_addr, mem_rd, ir_valid);
    end
    mem_ready = 1'b1;
    mem_rdata = 16'hDEAD;
    step();
    checks++;
    if (ir !== model_ir || ir_valid !== 1'b0 || mem_rd !== 1'b1 ||
        busy !== 1'b1 || mem_addr !== 16'h0040) begin
      errors++;
      $display("FAIL rk_drop got ir=%h v=%b rd=%b busy=%b addr=%h exp %h 0 1 1 0040",
               ir, ir_valid, mem_rd, busy, mem_addr, model_ir);
    end
    mem_rdata = 16'h1111;
    step();
    mem_ready = 1'b0;
    checks++;
    if (ir !== 16'h1111 || ir_valid !== 1'b1 || pc !== 16'h0041) begin
      errors++;
      $display("FAIL rk_refetch got ir=%h v=%b pc=%h exp 1111 1 0041",
               ir, ir_valid, pc);
    end
    model_pc = 16'h0041;
    model_ir = 16'h1111;
    step();
  endtask

  task automatic test_wrap();
    logic [15:0] w;
    redirect = 1'b1;
    redirect_pc = 16'h1234;
    step();
    redirect = 1'b0;
    checks++;
    if (pc !== 16'h1234 || mem_rd !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_redir got pc=%h rd=%b busy=%b exp 1234 0 0",
               pc, mem_rd, busy);
    end
    redirect = 1'b1;
    redirect_pc = 16'hFFFF;
    fetch_req = 1'b1;
    step();
    redirect = 1'b0;
    fetch_req = 1'b0;
    checks++;
    if (mem_addr !== 16'hFFFF || mem_rd !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle got addr=%h rd=%b exp ffff 1", mem_addr, mem_rd);
    end
    w = 16'($urandom);
    mem_ready = 1'b1;
    mem_rdata = w;
    step();
    mem_ready = 1'b0;
    checks++;
    if (pc !== 16'h0000 || ir !== w || ir_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap got pc=%h ir=%h v=%b exp 0000 %h 1",
               pc, ir, ir_valid, w);
    end
    model_pc = 16'h0000;
    model_ir = w;
    step();
  endtask

  task automatic test_reset_mid_fetch();
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    #2;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 16'hBEEF;
    step();
    mem_ready = 1'b0;
    checks++;
    if (ir !== 16'h0000 || ir_valid !== 1'b0 || pc !== 16'h0000 ||
        mem_rd !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got ir=%h v=%b pc=%h rd=%b exp 0000 0 0000 0",
               ir, ir_valid, pc, mem_rd);
    end
    step();
    checks++;
    if (ir_valid !== 1'b0 || ir !== 16'h0000) begin
      errors++;
      $display("FAIL rst_mid_late got v=%b ir=%h exp 0 0000", ir_valid, ir);
    end
    model_pc = 16'h0000;
    model_ir = 16'h0000;
  endtask

  // Random fetch stream, issued back to back (next request raised in
  // the ir_valid cycle). Any redirect during a fetch costs exactly one
  // dropped word before the new target is read.
  task automatic test_back_to_back();
    int bad = 0;
    int mode;
    int waits;
    int redir_at;
    logic [15:0] w;
    logic [15:0] tgt;
    for (int k = 0; k < 40; k++) begin
      mode = $urandom_range(0, 3);
      waits = $urandom_range(0, 3);
      redir_at = (waits > 0) ? $urandom_range(0, waits - 1) : -1;
      fetch_req = 1'b1;
      if (mode == 3) begin
        tgt = 16'($urandom);
        redirect = 1'b1;
        redirect_pc = tgt;
        model_pc = tgt;
      end
      step();
      fetch_req = 1'b0;
      redirect = 1'b0;
      if (ir_valid !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== model_pc)
        bad++;
      for (int i = 0; i < waits; i++) begin
        if (mode == 1 && i == redir_at) begin
          tgt = 16'($urandom);
          redirect = 1'b1;
          redirect_pc = tgt;
        end
        step();
        redirect = 1'b0;
        if (mode == 1 && i == redir_at)
          model_pc = tgt;
        if (ir_valid !== 1'b0 || mem_rd !== 1'b1 ||
            mem_addr !== model_pc || ir !== model_ir)
          bad++;
      end
      if ((mode == 1 && waits > 0) || mode == 2) begin
        mem_ready = 1'b1;
        mem_rdata = 16'($urandom);
        if (mode == 2) begin
          tgt = 16'($urandom);
          redirect = 1'b1;
          redirect_pc = tgt;
          model_pc = tgt;
        end
        step();
        redirect = 1'b0;
        if (ir_valid !== 1'b0 || mem_rd !== 1'b1 ||
            mem_addr !== model_pc || ir !== model_ir)
          bad++;
      end
      w = 16'($urandom);
      mem_ready = 1'b1;
      mem_rdata = w;
      step();
      mem_ready = 1'b0;
      model_ir = w;
      model_pc = model_pc + 16'd1;
      checks++;
      if (ir !== model_ir || ir_valid !== 1'b1 || pc !== model_pc ||
          mem_rd !== 1'b0) begin
        errors++;
        $display("FAIL b2b_load[%0d] got ir=%h v=%b pc=%h rd=%b exp %h 1 %h 0",
                 k, ir, ir_valid, pc, mem_rd, model_ir, model_pc);
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL b2b_inflight got %0d bad cycles exp 0", bad);
    end
    step();
  endtask

  initial begin
    model_pc = 16'h0000;
    model_ir = 16'h0000;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_redirect_kill();
    test_wrap();
    test_reset_mid_fetch();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
